// File: rtl/crc_one_check.sv
// Receive-side CRC checker: serially re-divides {data, crc} by G(x)
// and reports syndrome, pass flag, recovered data and an error count.
module crc_one_check #(
   parameter int                DATA_W = 3,
   parameter int                CRC_W  = 4,
   parameter logic [CRC_W-1:0]  POLY   = 4'b0011,
   parameter int                CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CRC_W-1:0]  i_crc_code,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_ok,
   output logic [CRC_W-1:0]  o_syndrome,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_err_cnt
);

   localparam int N   = DATA_W + CRC_W;
   localparam int C_W = $clog2(N);

   localparam logic [C_W-1:0] LAST = C_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      sr_q, sr_d;
   logic [CRC_W-1:0]  r_q, r_d;
   logic [C_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              done_q, done_d;
   logic              ok_q, ok_d;
   logic [CRC_W-1:0]  syn_q, syn_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  err_q, err_d;

   logic              accept;
   logic [CRC_W-1:0]  r_step;

   // One division step: shift the next codeword bit in, reduce by G.
   assign r_step = {r_q[CRC_W-2:0], sr_q[N-1]}
                 ^ (r_q[CRC_W-1] ? POLY : '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         syn_q   <= '0;
         data_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         syn_q   <= syn_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      syn_d   = syn_q;
      data_d  = data_q;
      err_d   = err_q;
      accept  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            accept = i_valid;
         end
         S_SHIFT: begin
            sr_d  = sr_q << 1;
            r_d   = r_step;
            cnt_d = cnt_q + C_W'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            ok_d    = (r_q == '0);
            syn_d   = r_q;
            data_d  = hold_q;
            state_d = S_IDLE;
            if ((r_q != '0) && (err_q != '1)) begin
               err_d = err_q + CNT_W'(1);
            end
            accept = i_valid;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Accept path is shared by IDLE and DONE so back-to-back words lose no cycle.
      if (accept) begin
         sr_d    = {i_data, i_crc_code};
         hold_d  = i_data;
         r_d     = '0;
         cnt_d   = '0;
         state_d = S_SHIFT;
      end
   end

   assign o_busy     = (state_q == S_SHIFT);
   assign o_done     = done_q;
   assign o_ok       = ok_q;
   assign o_syndrome = syn_q;
   assign o_data     = data_q;
   assign o_err_cnt  = err_q;

endmodule
